// File: rtl/dcpu_mem_pkg.sv
// rtl/dcpu_mem_pkg.sv - shared types and constants for the DCPU-16 memory arbiter
package dcpu_mem_pkg;

  localparam int AWIDTH_DEF = 15;
  localparam int DWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_COMPLETE = 2'd2
  } arb_state_e;

  // One-hot select for a requester index (bit 0 = cpu, bit 1 = dma)
  function automatic logic [1:0] port_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - one requester port of the memory arbiter (req/ack handshake)
interface mem_arbiter_if #(
  parameter int AWIDTH = dcpu_mem_pkg::AWIDTH_DEF,
  parameter int DWIDTH = dcpu_mem_pkg::DWIDTH_DEF
);
  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              ack;
  logic [DWIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner selection; MEM_ARB_RR_EN selects round-robin, else fixed priority
module mem_arb_pick (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  logic [1:0] eff_req;
  logic       unused_last;

  assign eff_req     = req & ~mask;
  assign unused_last = last;

  // Pick among unmasked requesters; only a tie depends on the policy
  always_comb begin
    gnt_valid = |eff_req;
    gnt_idx   = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (eff_req == 2'b11) gnt_idx = ~last;
    else                  gnt_idx = eff_req[1];
`else
    gnt_idx = eff_req[1] & ~eff_req[0];
`endif
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for the single-port word memory (MEM_ARB_RR_EN: round-robin ties)
module mem_arbiter
  import dcpu_mem_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      p0,
  mem_arbiter_if.slave      p1,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-1:0] memaddr,
  output logic [DWIDTH-1:0] wmemdata,
  input  logic [DWIDTH-1:0] rmemdata
);
  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              op_we_q, op_we_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] memaddr_q, memaddr_d;
  logic [DWIDTH-1:0] wmemdata_q, wmemdata_d;
  logic [1:0]        ack_q, ack_d;

  logic [1:0]        pick_mask;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              grant;
  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  // The owner is masked while it is being acked so the other port gets the next slot
  assign pick_mask = (state_q == ARB_COMPLETE) ? port_mask(owner_q) : 2'b00;

  mem_arb_pick u_pick (
    .req       ({p1.req, p0.req}),
    .mask      (pick_mask),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_we    = gnt_idx ? p1.we    : p0.we;
  assign sel_addr  = gnt_idx ? p1.addr  : p0.addr;
  assign sel_wdata = gnt_idx ? p1.wdata : p0.wdata;

  // Next-state and next-output computation for the IDLE/ISSUE/COMPLETE sequence
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    op_we_d    = op_we_q;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    memaddr_d  = memaddr_q;
    wmemdata_d = wmemdata_q;
    ack_d      = 2'b00;
    grant      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        grant = gnt_valid;
      end
      ARB_ISSUE: begin
        state_d = ARB_COMPLETE;
        ack_d   = port_mask(owner_q);
      end
      ARB_COMPLETE: begin
        grant = gnt_valid;
        if (!gnt_valid) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (grant) begin
      state_d   = ARB_ISSUE;
      owner_d   = gnt_idx;
      last_d    = gnt_idx;
      op_we_d   = sel_we;
      mem_re_d  = ~sel_we;
      mem_we_d  = sel_we;
      memaddr_d = sel_addr;
      if (sel_we) wmemdata_d = sel_wdata;
    end
  end

  // State and registered outputs; reset drops any pending ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      op_we_q    <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      memaddr_q  <= '0;
      wmemdata_q <= '0;
      ack_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      op_we_q    <= op_we_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      memaddr_q  <= memaddr_d;
      wmemdata_q <= wmemdata_d;
      ack_q      <= ack_d;
    end
  end

  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign memaddr  = memaddr_q;
  assign wmemdata = wmemdata_q;

  // Read data is only presented alongside the ack of a read owner
  assign p0.ack   = ack_q[0];
  assign p1.ack   = ack_q[1];
  assign p0.rdata = (ack_q[0] && !op_we_q) ? rmemdata : '0;
  assign p1.rdata = (ack_q[1] && !op_we_q) ? rmemdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (honours MEM_ARB_RR_EN)
module tb_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  typedef struct {
    int          port;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_re, mem_we;
  logic [AW-1:0] memaddr;
  logic [DW-1:0] wmemdata;
  logic [DW-1:0] rmemdata = '0;

  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) p0_bus ();
  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) p1_bus ();

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0       (p0_bus),
    .p1       (p1_bus),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .memaddr  (memaddr),
    .wmemdata (wmemdata),
    .rmemdata (rmemdata)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    cont_en = 1'b0;
  int    last_ack [2];
  xfer_t iq [$];
  xfer_t aq [$];
  xfer_t tbl [7];

  logic [DW-1:0] mem_arr [int];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return {1'b0, a} ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem_arr[int'(memaddr)] = wmemdata;
  end

  always @(posedge clk) begin
    rmemdata <= mem_re ? mem_rd(memaddr) : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic port_ack(input int port);
    return (port == 0) ? p0_bus.ack : p1_bus.ack;
  endfunction

  task automatic drive(input int port, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) begin
      p0_bus.req = r; p0_bus.we = w; p0_bus.addr = a; p0_bus.wdata = d;
    end else begin
      p1_bus.req = r; p1_bus.we = w; p1_bus.addr = a; p1_bus.wdata = d;
    end
  endtask

  task automatic wait_ack(input int port, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!port_ack(port) && n < 12);
  endtask

  task automatic push(input xfer_t x);
    iq.push_back(x);
    aq.push_back(x);
  endtask

  task automatic do_xfer(input xfer_t x);
    int n;
    push(x);
    @(negedge clk);
    drive(x.port, 1'b1, x.we, x.addr, x.wdata);
    wait_ack(x.port, n);
    check("xfer_latency", n, 2);
    drive(x.port, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic tie(input int first);
    xfer_t a, b;
    int    n;
    a = '{port: 0, we: 1'b0, addr: 15'h0010, wdata: 16'h0, rdata: 16'hBEEF};
    b = '{port: 1, we: 1'b0, addr: 15'h0123, wdata: 16'h0, rdata: 16'h5B79};
    if (first == 0) begin push(a); push(b); end
    else            begin push(b); push(a); end
    @(negedge clk);
    drive(0, 1'b1, a.we, a.addr, a.wdata);
    drive(1, 1'b1, b.we, b.addr, b.wdata);
    wait_ack(first, n);
    check("tie_first_latency", n, 2);
    drive(first, 1'b0, 1'b0, '0, '0);
    wait_ack(1 - first, n);
    check("tie_second_gap", n, 2);
    drive(1 - first, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  // Scoreboard: strobes and acks are matched in order against the expected queues
  always @(negedge clk) begin
    if (mon_en) begin
      xfer_t e;
      logic  ack;
      logic [DW-1:0] rd;
      cyc++;
      check("ack_exclusive", 32'(p0_bus.ack && p1_bus.ack), 32'(0));
      if (mem_re || mem_we) begin
        check("strobe_exclusive", 32'(mem_re && mem_we), 32'(0));
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got re=%0b we=%0b addr=%0h expected none", mem_re, mem_we, memaddr);
        end else begin
          e = iq.pop_front();
          check("strobe_we", 32'(mem_we), 32'(e.we));
          check("strobe_addr", 32'(memaddr), 32'(e.addr));
          if (e.we) check("strobe_wdata", 32'(wmemdata), 32'(e.wdata));
        end
      end
      for (int p = 0; p < 2; p++) begin
        ack = (p == 0) ? p0_bus.ack : p1_bus.ack;
        rd  = (p == 0) ? p0_bus.rdata : p1_bus.rdata;
        if (ack) begin
          if (aq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack: got ack on port %0d expected none", p);
          end else begin
            e = aq.pop_front();
            check("ack_port", p, e.port);
            check("ack_rdata", 32'(rd), 32'(e.rdata));
          end
          if (cont_en && last_ack[p] >= 0)
            check("cont_wait_le4", 32'((cyc - last_ack[p]) <= 4), 32'(1));
          last_ack[p] = cyc;
        end else begin
          check("rdata_idle_zero", 32'(rd), 32'(0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, acks;
    tbl[0] = '{port: 1, we: 1'b1, addr: 15'h7FFF, wdata: 16'h1234, rdata: 16'h0000};
    tbl[1] = '{port: 0, we: 1'b0, addr: 15'h7FFF, wdata: 16'h0000, rdata: 16'h1234};
    tbl[2] = '{port: 0, we: 1'b0, addr: 15'h0010, wdata: 16'h0000, rdata: 16'hBEEF};
    tbl[3] = '{port: 0, we: 1'b1, addr: 15'h0000, wdata: 16'hFFFF, rdata: 16'h0000};
    tbl[4] = '{port: 1, we: 1'b0, addr: 15'h0000, wdata: 16'h0000, rdata: 16'hFFFF};
    tbl[5] = '{port: 1, we: 1'b0, addr: 15'h0123, wdata: 16'h0000, rdata: 16'h5B79};
    tbl[6] = '{port: 0, we: 1'b1, addr: 15'h2000, wdata: 16'hA5A5, rdata: 16'h0000};
    mem_arr[16] = 16'hBEEF;

    // Reset held with both requests up
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 15'h0010, 16'h0);
    drive(1, 1'b1, 1'b1, 15'h0123, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mem_re", 32'(mem_re), 32'(0));
      check("rst_mem_we", 32'(mem_we), 32'(0));
      check("rst_ack0", 32'(p0_bus.ack), 32'(0));
      check("rst_ack1", 32'(p1_bus.ack), 32'(0));
      check("rst_memaddr", 32'(memaddr), 32'(0));
    end
    check("rst_wmemdata", 32'(wmemdata), 32'(0));
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    mon_en = 1'b1;

    // First tie after reset: cpu wins in both builds
    tie(0);

    // Single transfers from the vector table
    for (int i = 0; i < 7; i++) do_xfer(tbl[i]);
    do_xfer('{port: 1, we: 1'b0, addr: 15'h2000, wdata: 16'h0, rdata: 16'hA5A5});

    // Continuous load on both ports: strict alternation, bounded wait
    for (int i = 0; i < 5; i++) begin
      push('{port: 0, we: 1'b0, addr: 15'h0010, wdata: 16'h0, rdata: 16'hBEEF});
      push('{port: 1, we: 1'b0, addr: 15'h0123, wdata: 16'h0, rdata: 16'h5B79});
    end
    last_ack[0] = -1;
    last_ack[1] = -1;
    cont_en = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 15'h0010, 16'h0);
    drive(1, 1'b1, 1'b0, 15'h0123, 16'h0);
    acks = 0;
    for (int i = 0; i < 40 && acks < 10; i++) begin
      @(negedge clk);
      if (p0_bus.ack || p1_bus.ack) acks++;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("cont_ack_count", acks, 10);
    @(negedge clk);
    cont_en = 1'b0;

    // A cpu grant followed by a tie: round-robin hands the tie to the dma port
    do_xfer('{port: 0, we: 1'b0, addr: 15'h0123, wdata: 16'h0, rdata: 16'h5B79});
`ifdef MEM_ARB_RR_EN
    tie(1);
`else
    tie(0);
`endif

    // Reset during the ISSUE cycle of a cpu read
    iq.push_back('{port: 0, we: 1'b0, addr: 15'h0010, wdata: 16'h0, rdata: 16'hBEEF});
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 15'h0010, 16'h0);
    @(negedge clk);
    check("midrst_issue_re", 32'(mem_re), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ack0", 32'(p0_bus.ack), 32'(0));
    check("midrst_mem_re", 32'(mem_re), 32'(0));
    drive(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_after_ack0", 32'(p0_bus.ack), 32'(0));
    check("midrst_after_re", 32'(mem_re), 32'(0));
    do_xfer('{port: 0, we: 1'b0, addr: 15'h0010, wdata: 16'h0, rdata: 16'hBEEF});

    repeat (2) @(negedge clk);
    check("issue_queue_drained", iq.size(), 0);
    check("ack_queue_drained", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
